// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to excess-3 sequential converter.
// Build option: define BCD_XS3_CHECK_EN to flag digits above 9 and force them to 4'hF.
package bcd_xs3_pkg;

  localparam int NIBBLE = 4;

  localparam logic [NIBBLE-1:0] XS3_OFFSET = 4'd3;
  localparam logic [NIBBLE-1:0] BCD_MAX    = 4'd9;
  localparam logic [NIBBLE-1:0] XS3_BAD    = 4'hF;

`ifdef BCD_XS3_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Single-nibble BCD to excess-3 converter, shared by all digits of the controller.
// With BCD_XS3_CHECK_EN defined, non-decimal nibbles map to 4'hF instead of wrapping.
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [NIBBLE-1:0] bcd_i,
  output logic [NIBBLE-1:0] xs3_o,
  output logic              invalid_o
);

  // Out-of-range detection is always computed; only the checked build acts on it.
  always_comb begin
    invalid_o = (bcd_i > BCD_MAX);
    if (CHECK_EN && invalid_o) begin
      xs3_o = XS3_BAD;
    end else begin
      xs3_o = bcd_i + XS3_OFFSET;
    end
  end

endmodule

// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD to excess-3 controller: converts one digit per cycle, LSD first.
// Build option BCD_XS3_CHECK_EN (see bcd_xs3_pkg) enables the sticky err flag.
module bcd_xs3_seq
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIBBLE*DIGITS-1:0] in_bcd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIBBLE*DIGITS-1:0] out_xs3,
  output logic                     err,
  output logic                     busy
);

  localparam int W  = NIBBLE * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    cap_q, cap_d;
  logic [W-1:0]    res_q, res_d;
  logic            err_q, err_d;

  logic [NIBBLE-1:0] digitBcd;
  logic [NIBBLE-1:0] digitXs3;
  logic              digitInvalid;

  // Select the captured digit addressed by the counter.
  always_comb begin
    digitBcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        digitBcd = cap_q[i*NIBBLE +: NIBBLE];
      end
    end
  end

  bcd_xs3_digit u_digit (
    .bcd_i     (digitBcd),
    .xs3_o     (digitXs3),
    .invalid_o (digitInvalid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    res_d     = res_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cap_d   = in_bcd;
          res_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CW'(i)) begin
            res_d[i*NIBBLE +: NIBBLE] = digitXs3;
          end
        end
        err_d = err_q | (CHECK_EN & digitInvalid);
        // Counter parks at zero once the last digit is written so it never wraps.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign out_xs3 = res_q;
  assign err     = err_q;

endmodule
